seg_display_arbiter: RTL and testbench

Time-shares the board's 8-digit seven-segment display between up to NREQ on-chip requesters, such as the CPU debug register, the program counter and the GEMM accelerator status. Each requester posts a 32-bit value into its own shadow register. A round-robin scheduler with a fixed dwell time picks which shadow drives the 32-bit display word, and a manual pin override is provided for debug. The block sits between the datapath and the seven-segment multiplexing driver, feeding that driver's 32-bit hex input.

---
 rtl/seg_display_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_display_arbiter: shares one 32-bit seven-segment word among requesters  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module seg_display_arbiter #(
    parameter int NREQ  = 4,
    parameter int DWELL = 50_000_000,
    parameter int SW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   data,
    input  logic [NREQ-1:0]      update,
    input  logic                 pin_en,
    input  logic [SW-1:0]        pin_sel,
    input  logic                 freeze,
    output logic [31:0]          disp_x,
    output logic [SW-1:0]        disp_src,
    output logic [NREQ-1:0]      grant,
    output logic                 disp_blank
);

    localparam int            CW         = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DWELL - 1);
    localparam logic [SW:0]   NREQ_W     = (SW + 1)'(NREQ);
    localparam logic [SW-1:0] LAST_IDX   = SW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_PINNED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       owner_q, owner_d;
    logic [SW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         disp_x_q, disp_x_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                blank_q, blank_d;
    logic [31:0]         shadow_q [NREQ];
    logic [31:0]         shadow_d [NREQ];

    logic [SW:0]         pick_ptr;
    logic [SW:0]         pick_nxt;
    logic                pin_ok;
    logic                rearb;

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + SW'(1);
    endfunction

    // Returns {found, index} of the first set request at or above start, wrapping.
    function automatic logic [SW:0] rr_pick(input logic [NREQ-1:0] r, input logic [SW-1:0] start);
        logic [SW:0]   res;
        logic [SW-1:0] idx;
        int            k;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = int'(start) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            idx = SW'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            shadow_d[i] = update[i] ? data[32*i +: 32] : shadow_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        rearb    = 1'b0;
        pick_ptr = rr_pick(req, rr_ptr_q);
        pick_nxt = rr_pick(req, wrap_inc(owner_q));
        pin_ok   = pin_en && ({1'b0, pin_sel} < NREQ_W);

        if (pin_ok) begin
            state_d = ST_PINNED;
            owner_d = pin_sel;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_ptr[SW]) begin
                        state_d  = ST_SHOW;
                        owner_d  = pick_ptr[SW-1:0];
                        cnt_d    = CNT_RELOAD;
                        rr_ptr_d = wrap_inc(pick_ptr[SW-1:0]);
                    end
                end
                ST_SHOW: begin
                    // A dropped request or an expired slot both hand over immediately.
                    if (!req[owner_q] || (cnt_q == '0)) begin
                        rearb = 1'b1;
                    end else if (!freeze) begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_PINNED: begin
                    if (req[owner_q]) begin
                        state_d = ST_SHOW;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        rearb = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (rearb) begin
                if (pick_nxt[SW]) begin
                    state_d  = ST_SHOW;
                    owner_d  = pick_nxt[SW-1:0];
                    cnt_d    = CNT_RELOAD;
                    rr_ptr_d = wrap_inc(pick_nxt[SW-1:0]);
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end

        grant_d = '0;
        if (state_d != ST_IDLE) begin
            grant_d[owner_d] = 1'b1;
        end
        blank_d = (state_d == ST_IDLE);

        // The display word follows the owner registered last cycle, one cycle behind grant.
        disp_x_d = disp_x_q;
        if ((state_q != ST_IDLE) && !freeze) begin
            disp_x_d = shadow_q[owner_q];
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            disp_x_q <= '0;
            grant_q  <= '0;
            blank_q  <= 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            disp_x_q <= disp_x_d;
            grant_q  <= grant_d;
            blank_q  <= blank_d;
            for (int i = 0; i < NREQ; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign disp_x     = disp_x_q;
    assign disp_src   = owner_q;
    assign grant      = grant_q;
    assign disp_blank = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg_display_arbiter: vector table and corner sequences, NREQ=4 DWELL=4    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_seg_display_arbiter;

    localparam logic [31:0]  X1 = 32'h11111111;
    localparam logic [31:0]  X2 = 32'h22222222;
    localparam logic [31:0]  X3 = 32'h33333333;
    localparam logic [31:0]  X4 = 32'h44444444;
    localparam logic [31:0]  XD = 32'hDEADBEEF;
    localparam logic [127:0] DATA_BASE = {X4, X3, X2, X1};

    logic         clk;
    logic         clr_n;
    logic [3:0]   req;
    logic [127:0] data;
    logic [3:0]   update;
    logic         pin_en;
    logic [1:0]   pin_sel;
    logic         freeze;
    logic [31:0]  disp_x;
    logic [1:0]   disp_src;
    logic [3:0]   grant;
    logic         disp_blank;

    seg_display_arbiter #(
        .NREQ  (4),
        .DWELL (4)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .req        (req),
        .data       (data),
        .update     (update),
        .pin_en     (pin_en),
        .pin_sel    (pin_sel),
        .freeze     (freeze),
        .disp_x     (disp_x),
        .disp_src   (disp_src),
        .grant      (grant),
        .disp_blank (disp_blank)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  upd;
        logic        pe;
        logic [1:0]  ps;
        logic        frz;
        logic [3:0]  e_grant;
        logic [1:0]  e_src;
        logic        e_blank;
        logic [31:0] e_dx;
        logic        chk_src;
        logic        chk_dx;
    } vec_t;

    vec_t tbl [13];
    vec_t sb [$];
    int   n_vec;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] up, input logic pe,
                                input logic [1:0] ps, input logic fz, input logic [3:0] g,
                                input logic [1:0] s, input logic b, input logic [31:0] x,
                                input logic cs, input logic cx);
        vec_t v;
        v.req = rq; v.upd = up; v.pe = pe; v.ps = ps; v.frz = fz;
        v.e_grant = g; v.e_src = s; v.e_blank = b; v.e_dx = x;
        v.chk_src = cs; v.chk_dx = cx;
        return v;
    endfunction

    task automatic check(input vec_t e, input string nm);
        logic ok;
        n_vec++;
        ok = (grant === e.e_grant) && (disp_blank === e.e_blank) &&
             (disp_blank === (grant == 4'b0000));
        if (e.chk_src) ok = ok && (disp_src === e.e_src);
        if (e.chk_dx)  ok = ok && (disp_x === e.e_dx);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got grant=%b src=%0d blank=%b x=%h, want grant=%b src=%0d blank=%b x=%h",
                     nm, grant, disp_src, disp_blank, disp_x,
                     e.e_grant, e.e_src, e.e_blank, e.e_dx);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare once the edge has passed.
    task automatic step(input vec_t v, input string nm);
        vec_t e;
        req     = v.req;
        update  = v.upd;
        pin_en  = v.pe;
        pin_sel = v.ps;
        freeze  = v.frz;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got 0 entries, want 1", nm);
        end else begin
            e = sb.pop_front();
            check(e, nm);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;

        // Round robin over req=0101 with shadows 0..3 preloaded.
        tbl[0]  = mk(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 1'b1, 32'h0, 1'b1, 1'b1);
        tbl[1]  = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
        tbl[2]  = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, X1,    1'b1, 1'b1);
        tbl[3]  = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, X1,    1'b1, 1'b1);
        tbl[4]  = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, X1,    1'b1, 1'b1);
        tbl[5]  = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 2'd2, 1'b0, X1,    1'b1, 1'b1);
        tbl[6]  = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 2'd2, 1'b0, X3,    1'b1, 1'b1);
        tbl[7]  = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 2'd2, 1'b0, X3,    1'b1, 1'b1);
        tbl[8]  = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 2'd2, 1'b0, X3,    1'b1, 1'b1);
        tbl[9]  = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, X3,    1'b1, 1'b1);
        tbl[10] = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, X1,    1'b1, 1'b1);
        tbl[11] = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, X1,    1'b1, 1'b1);
        tbl[12] = mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, X1,    1'b1, 1'b1);

        clr_n   = 1'b0;
        req     = '0;
        data    = DATA_BASE;
        update  = '0;
        pin_en  = 1'b0;
        pin_sel = '0;
        freeze  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(mk(4'b0, 4'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 1'b1, 32'h0, 1'b1, 1'b1), "reset_state");
        clr_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i], $sformatf("rr_vec%0d", i));
        end

        // Asynchronous reset mid-slot, observed between clock edges.
        #2 clr_n = 1'b0;
        #1 check(mk(4'b0, 4'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 1'b1, 32'h0, 1'b1, 1'b1), "async_reset");
        @(negedge clk);
        clr_n = 1'b1;

        // Early drop of the owner's request on cycle 2 of its slot.
        step(mk(4'b0011, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1), "drop_e1");
        step(mk(4'b0011, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, X1,    1'b1, 1'b1), "drop_e2");
        step(mk(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 2'd1, 1'b0, X1,    1'b1, 1'b1), "drop_e3");
        for (int i = 0; i < 3; i++) begin
            step(mk(4'b0011, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 2'd1, 1'b0, X2, 1'b1, 1'b1),
                 $sformatf("drop_hold%0d", i));
        end
        step(mk(4'b0011, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, X2,    1'b1, 1'b1), "drop_e7");

        // Pin requester 3 while only requester 0 asks, then move and release the pin.
        step(mk(4'b0001, 4'b0000, 1'b1, 2'd3, 1'b0, 4'b1000, 2'd3, 1'b0, X1,    1'b1, 1'b1), "pin_first");
        for (int i = 0; i < 19; i++) begin
            step(mk(4'b0001, 4'b0000, 1'b1, 2'd3, 1'b0, 4'b1000, 2'd3, 1'b0, X4, 1'b1, 1'b1),
                 $sformatf("pin_hold%0d", i));
        end
        step(mk(4'b0001, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0010, 2'd1, 1'b0, X4,    1'b1, 1'b1), "pin_move");
        step(mk(4'b0001, 4'b0000, 1'b0, 2'd1, 1'b0, 4'b0001, 2'd0, 1'b0, X2,    1'b1, 1'b1), "pin_release");

        // Freeze with owner 2 while a shadow update arrives.
        step(mk(4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 2'd2, 1'b0, X1,    1'b1, 1'b1), "frz_owner");
        step(mk(4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 2'd2, 1'b0, X3,    1'b1, 1'b1), "frz_show");
        step(mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0100, 2'd2, 1'b0, X3,    1'b1, 1'b1), "frz_on");
        data[95:64] = XD;
        step(mk(4'b0101, 4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 2'd2, 1'b0, X3,    1'b1, 1'b1), "frz_update");
        for (int i = 0; i < 6; i++) begin
            step(mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0100, 2'd2, 1'b0, X3, 1'b1, 1'b1),
                 $sformatf("frz_hold%0d", i));
        end
        step(mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 2'd2, 1'b0, XD,    1'b1, 1'b1), "frz_release");
        step(mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 2'd2, 1'b0, XD,    1'b1, 1'b1), "frz_tail");
        step(mk(4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b0, XD,    1'b1, 1'b1), "frz_rotate");

        // All requests drop, then requester 1 returns.
        step(mk(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 1'b1, X1,    1'b0, 1'b1), "idle_enter");
        step(mk(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 1'b1, X1,    1'b0, 1'b1), "idle_hold");
        step(mk(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 2'd1, 1'b0, X1,    1'b1, 1'b1), "idle_exit");
        step(mk(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 2'd1, 1'b0, X2,    1'b1, 1'b1), "idle_show");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
